ft600_rx_deframer: RTL and testbench
====================================

# ft600_rx_deframer

Consumes the receive byte stream of the FT600 245-mode bridge and extracts checksummed command frames. Each frame is buffered in full and its checksum verified before any byte is released downstream, so consumers only ever see complete, valid frames. The block sits between the bridge's `rx_en`/`rx_out`/`rx_empty` FIFO port and the command-handling logic. It runs entirely in the system `clk` domain.

## Interface
- `MAX_LEN`, 64: maximum payload length in bytes; also the frame buffer depth.
- `SYNC`, 8'hA5: start-of-frame byte.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-low.
- `rx_en` out 1: pop strobe to the bridge RX FIFO.
- `rx_out` in 8: head byte of the RX FIFO, first-word-fall-through; valid while `rx_empty`=0.
- `rx_empty` in 1: RX FIFO empty.
- `out_data` out 8: released frame byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the byte.
- `out_first` out 1: current byte is CMD, the first byte of the frame.
- `out_last` out 1: current byte is the final byte of the frame.
- `frame_err` out 1: one-cycle pulse when a frame is dropped.
- `err_count` out 16: number of dropped frames; saturates at 16'hFFFF.

## Operation
- Frame format: `SYNC`, LEN, CMD, LEN payload bytes, CHK.
- The frame is valid when (LEN + CMD + payload + CHK) mod 256 = 0.
- LEN = 0 is legal.
- A byte is consumed when `rx_en` & !`rx_empty`.
- `rx_en` = !`rx_empty` in every state except EMIT. It is combinational and forced to 0 while `rst`=0.
- States and transitions:
  - HUNT: discard bytes until one equals `SYNC`, then go to LEN.
  - LEN: latch LEN and seed the running sum.
    - If LEN > `MAX_LEN`: pulse `frame_err`, increment `err_count`, return to HUNT. The LEN byte itself is not re-examined as a sync byte.
    - Otherwise go to CMD.
  - CMD: latch CMD and add it to the sum. Go to PAYLOAD, or to CHECK if LEN = 0.
  - PAYLOAD: write each byte to buffer[idx], add it to the sum, increment idx. After LEN bytes, go to CHECK.
  - CHECK: consume CHK.
    - If the sum plus CHK is nonzero mod 256: pulse `frame_err`, increment `err_count`, go to HUNT.
    - Otherwise go to EMIT.
  - EMIT: present CMD with `out_first`=1, then buffer[0..LEN-1]. `out_last`=1 on the final byte (on CMD itself when LEN = 0). After the final handshake, go to HUNT.
- The running sum is 8 bits and wraps.
- idx is `$clog2(MAX_LEN+1)` bits wide.
- The buffer is overwritten by every frame. No partial frame is ever emitted.

## Timing
- Reset values: `rx_en`=0, `out_data`=0, `out_valid`=0, `out_first`=0, `out_last`=0, `frame_err`=0, `err_count`=0. State resets to HUNT and idx to 0.
- Throughput is one byte per cycle in all capture states when the FIFO is non-empty. Gaps in `rx_empty` stall parsing without corrupting it.
- `out_valid` rises exactly 1 cycle after the CHK byte is consumed. With `out_ready` held at 1, EMIT lasts LEN+1 cycles.
- Output handshake:
  - A transfer occurs when `out_valid` & `out_ready`.
  - While `out_ready`=0, `out_data`, `out_first` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
- No pops occur during EMIT. The first pop of the next frame happens in the cycle after the final handshake.
- `frame_err` is asserted in the cycle after the offending byte is consumed.
- Reset asserted mid-frame or mid-EMIT: outputs clear immediately; any partial frame is lost and not counted as an error.

## Structure
- A shared package `ft600_pkg` holds the state enum, the default `SYNC` value, and a checksum helper function.
- One sub-module, `ft600_frame_buf`: a `MAX_LEN`x8 synchronous RAM with one write port and one read port and 1-cycle read latency. The EMIT logic prefetches so that the output streams back-to-back.

## Test plan
- Valid frame: A5 03 10 11 22 33 87 -> out 10(first) 11 22 33(last); `frame_err` stays 0.
- Bad checksum: A5 03 10 11 22 33 88 -> no output; one `frame_err` pulse; `err_count`=1. A following valid frame is then emitted normally.
- Zero length with leading garbage: 00 FF A5 00 42 BE -> single output byte 42 with `out_first`=`out_last`=1.
- Oversize length: A5 41 ... -> `frame_err` pulse and return to HUNT. A subsequent A5 02 01 AA BB 98 emits 01 AA BB.
- Backpressure and FIFO gaps: `out_ready` toggling randomly and `rx_empty` asserted for 3 cycles mid-payload -> byte order and flags intact, no duplicates or losses, `rx_en`=0 throughout EMIT.
- Reset mid-PAYLOAD: `rst` pulsed low -> outputs at reset values, `err_count` unchanged. The next full frame is parsed correctly.

Source files
------------

// File: rtl/ft600_pkg.sv
// rtl/ft600_pkg.sv - shared state encoding, sync default and checksum helper for the FT600 deframer
package ft600_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_CMD     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_EMIT    = 3'd5
  } ft600_state_e;

  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/ft600_frame_buf.sv
// rtl/ft600_frame_buf.sv - frame payload RAM, one write port, one read port, 1-cycle read latency
module ft600_frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ft600_rx_deframer.sv
// rtl/ft600_rx_deframer.sv - buffers SYNC/LEN/CMD/payload/CHK frames from the FT600 RX FIFO
// and releases only checksum-valid frames downstream.
module ft600_rx_deframer
  import ft600_pkg::*;
#(
  parameter int         MAX_LEN = 64,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rx_en,
  input  logic [7:0]  rx_out,
  input  logic        rx_empty,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic        frame_err,
  output logic [15:0] err_count
);

  localparam int         IW        = $clog2(MAX_LEN + 1);
  localparam int         AW        = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  ft600_state_e  state;
  logic [IW-1:0] len, idx, idx_nx, len_m1;
  logic [7:0]    cmd, sum, rd_data;
  logic [AW-1:0] rd_addr;
  logic          pop, drop, xfer, rd_en, wr_en;

  assign rx_en  = rst & ~rx_empty & (state != ST_EMIT);
  assign pop    = rx_en;
  assign xfer   = out_valid & out_ready;
  assign idx_nx = idx + IW'(1);
  assign len_m1 = len - IW'(1);
  assign drop   = pop & (((state == ST_LEN) & (rx_out > MAX_LEN_B)) |
                         ((state == ST_CHECK) & (chk_add(sum, rx_out) != 8'd0)));
  assign wr_en  = pop & (state == ST_PAYLOAD);

  // buffer[0] is fetched while CHK is consumed, buffer[n+1] on each EMIT handshake
  assign rd_en   = (pop & (state == ST_CHECK)) |
                   ((state == ST_EMIT) & xfer & ~out_last & (idx_nx < len));
  assign rd_addr = (state == ST_EMIT) ? idx_nx[AW-1:0] : '0;

  ft600_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx[AW-1:0]),
    .wr_data (rx_out),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_HUNT;
      len       <= '0;
      idx       <= '0;
      cmd       <= '0;
      sum       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_HUNT: if (pop && rx_out == SYNC) state <= ST_LEN;
        ST_LEN: if (pop) begin
          sum   <= rx_out;
          len   <= rx_out[IW-1:0];
          state <= (rx_out > MAX_LEN_B) ? ST_HUNT : ST_CMD;
        end
        ST_CMD: if (pop) begin
          cmd   <= rx_out;
          sum   <= chk_add(sum, rx_out);
          idx   <= '0;
          state <= (len == '0) ? ST_CHECK : ST_PAYLOAD;
        end
        ST_PAYLOAD: if (pop) begin
          sum <= chk_add(sum, rx_out);
          idx <= idx_nx;
          if (idx == len_m1) state <= ST_CHECK;
        end
        ST_CHECK: if (pop) begin
          idx <= '0;
          if (chk_add(sum, rx_out) != 8'd0) begin
            state <= ST_HUNT;
          end else begin
            state     <= ST_EMIT;
            out_valid <= 1'b1;
            out_data  <= cmd;
            out_first <= 1'b1;
            out_last  <= (len == '0);
          end
        end
        ST_EMIT: if (xfer) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            state     <= ST_HUNT;
          end else begin
            out_data  <= rd_data;
            out_first <= 1'b0;
            out_last  <= (idx == len_m1);
            idx       <= idx_nx;
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= drop;
      if (drop && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ft600_rx_deframer.sv
// tb/tb_ft600_rx_deframer.sv - randomized self-checking bench for ft600_rx_deframer against a frame-level model
module tb_ft600_rx_deframer;

  localparam int         MAX_LEN = 64;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_en;
  logic [7:0]  rx_out = 8'h00;
  logic        rx_empty = 1'b1;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first;
  logic        out_last;
  logic        frame_err;
  logic [15:0] err_count;

  ft600_rx_deframer #(.MAX_LEN(MAX_LEN), .SYNC(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .rx_out    (rx_out),
    .rx_empty  (rx_empty),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  logic [7:0] stim[$];
  logic [9:0] outq[$];
  logic [9:0] exp_q[$];
  int  exp_errs, err_total = 0;
  int  tests_run = 0, tests_failed = 0;
  int  err_pulses = 0, emit_pop_viol = 0, hold_viol = 0, pops = 0;
  int  gap_at = -1, gap_left = 0;
  int  cyc = 0, last_pop_cyc = 0, last_lat = 0, valid_run = 0, last_valid_len = 0;
  bit  rand_ready = 0, pop_pending = 0, held_valid = 0, prev_valid = 0;
  logic [9:0] held;

  // FIFO / sink driver: inputs change on the falling edge, DUT outputs are sampled 1 time unit later
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_pending && rxq.size() > 0) begin
        void'(rxq.pop_front());
        pops++;
      end
      if (pops == gap_at) begin
        gap_left = 3;
        gap_at   = -1;
      end
      rx_empty = (rxq.size() == 0) || (gap_left > 0);
      if (gap_left > 0) gap_left--;
      rx_out    = (rxq.size() > 0) ? rxq[0] : 8'h00;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (frame_err) err_pulses++;
      if (out_valid && rx_en) emit_pop_viol++;
      if (held_valid && (out_valid !== 1'b1 || {out_first, out_last, out_data} !== held)) hold_viol++;
      held_valid = out_valid && !out_ready;
      held       = {out_first, out_last, out_data};
      if (out_valid && out_ready) outq.push_back({out_first, out_last, out_data});
      if (out_valid && !prev_valid) begin
        last_lat  = cyc - last_pop_cyc;
        valid_run = 0;
      end
      if (out_valid) valid_run++;
      if (!out_valid && prev_valid) last_valid_len = valid_run;
      prev_valid  = out_valid;
      pop_pending = rx_en && !rx_empty;
      if (pop_pending) last_pop_cyc = cyc;
    end
  end

  // Frame-level reference: scan the byte stream by the frame rules, emitting {first,last,data}
  task automatic model(input logic [7:0] s[$]);
    int i = 0;
    int len, total;
    exp_q.delete();
    exp_errs = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= s.size()) break;
      len = int'(s[i+1]);
      if (len > MAX_LEN) begin
        exp_errs++;
        i += 2;
        continue;
      end
      if (i + 3 + len >= s.size()) break;
      total = 0;
      for (int k = 1; k <= 3 + len; k++) total += int'(s[i+k]);
      if (total % 256 != 0) begin
        exp_errs++;
      end else begin
        exp_q.push_back({1'b1, len == 0, s[i+2]});
        for (int p = 0; p < len; p++) exp_q.push_back({1'b0, p == len - 1, s[i+3+p]});
      end
      i += 4 + len;
    end
  endtask

  task automatic push_frame(input int len, input bit good);
    logic [7:0] b, s;
    b = 8'($urandom);
    stim.push_back(SYNC);
    stim.push_back(8'(len));
    stim.push_back(b);
    s = 8'(len) + b;
    for (int p = 0; p < len; p++) begin
      b = 8'($urandom);
      stim.push_back(b);
      s += b;
    end
    if (good) stim.push_back(8'h00 - s);
    else      stim.push_back(8'($urandom_range(1, 255)) - s);
  endtask

  task automatic run_stim(output bit ok);
    int idle = 0;
    int budget = 20000;
    model(stim);
    err_total = (err_total + exp_errs > 65535) ? 65535 : err_total + exp_errs;
    outq.delete();
    err_pulses = 0;
    emit_pop_viol = 0;
    hold_viol = 0;
    held_valid = 0;
    foreach (stim[k]) rxq.push_back(stim[k]);
    stim.delete();
    ok = 0;
    while (budget > 0) begin
      @(negedge clk);
      #2;
      if (rxq.size() == 0 && !out_valid && gap_left == 0) idle++;
      else idle = 0;
      if (idle >= 4) begin
        ok = 1;
        break;
      end
      budget--;
    end
    rand_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxq.push_back(8'h00);
    repeat (3) @(negedge clk);
    #2;
    tests_run++; if (rx_en !== 1'b0)      begin tests_failed++; $display("FAIL reset_rx_en got %b want 0", rx_en); end
    tests_run++; if (out_data !== 8'h00)  begin tests_failed++; $display("FAIL reset_out_data got %h want 00", out_data); end
    tests_run++; if (out_valid !== 1'b0)  begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (out_first !== 1'b0)  begin tests_failed++; $display("FAIL reset_out_first got %b want 0", out_first); end
    tests_run++; if (out_last !== 1'b0)   begin tests_failed++; $display("FAIL reset_out_last got %b want 0", out_last); end
    tests_run++; if (frame_err !== 1'b0)  begin tests_failed++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_payload();
    bit ok;
    int start;
    int budget = 200;
    push_frame(16, 1);
    foreach (stim[k]) rxq.push_back(stim[k]);
    stim.delete();
    start = pops;
    while (pops < start + 8 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests_run++; if (budget == 0) begin tests_failed++; $display("FAIL rstmid_timeout got %0d pops want 8", pops - start); end
    #3 rst = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0)  begin tests_failed++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    tests_run++; if (rx_en !== 1'b0)      begin tests_failed++; $display("FAIL rstmid_rx_en got %b want 0", rx_en); end
    tests_run++; if (frame_err !== 1'b0)  begin tests_failed++; $display("FAIL rstmid_frame_err got %b want 0", frame_err); end
    tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL rstmid_err_count got %0d want 0", err_count); end
    rxq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_frame(5, 1);
    run_stim(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rstmid_run_timeout got 0 want 1"); end
    tests_run++; if (outq.size() != exp_q.size()) begin tests_failed++; $display("FAIL rstmid_count got %0d want %0d", outq.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      tests_run++; if (outq[k] !== exp_q[k]) begin tests_failed++; $display("FAIL rstmid_byte%0d got %h want %h", k, outq[k], exp_q[k]); end
    end
    tests_run++; if (err_pulses != 0)      begin tests_failed++; $display("FAIL rstmid_err_pulses got %0d want 0", err_pulses); end
    tests_run++; if (err_count !== 16'd0)  begin tests_failed++; $display("FAIL rstmid_err_after got %0d want 0", err_count); end
  endtask

  task automatic test_valid_frame();
    bit ok;
    logic [9:0] want [4];
    want = '{10'h210, 10'h011, 10'h022, 10'h133};
    stim = {8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h87};
    run_stim(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL valid_timeout got 0 want 1"); end
    tests_run++; if (outq.size() != 4) begin tests_failed++; $display("FAIL valid_count got %0d want 4", outq.size()); end
    for (int k = 0; k < 4 && k < outq.size(); k++) begin
      tests_run++; if (outq[k] !== want[k]) begin tests_failed++; $display("FAIL valid_byte%0d got %h want %h", k, outq[k], want[k]); end
    end
    tests_run++; if (err_pulses != 0)    begin tests_failed++; $display("FAIL valid_err_pulses got %0d want 0", err_pulses); end
    tests_run++; if (last_lat != 1)      begin tests_failed++; $display("FAIL valid_latency got %0d want 1", last_lat); end
    tests_run++; if (last_valid_len != 4) begin tests_failed++; $display("FAIL valid_emit_cycles got %0d want 4", last_valid_len); end
  endtask

  task automatic test_bad_checksum();
    bit ok;
    logic [9:0] want [3];
    want = '{10'h201, 10'h0AA, 10'h1BB};
    stim = {8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h88, 8'hA5, 8'h02, 8'h01, 8'hAA, 8'hBB, 8'h98};
    run_stim(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL badchk_timeout got 0 want 1"); end
    tests_run++; if (outq.size() != 3) begin tests_failed++; $display("FAIL badchk_count got %0d want 3", outq.size()); end
    for (int k = 0; k < 3 && k < outq.size(); k++) begin
      tests_run++; if (outq[k] !== want[k]) begin tests_failed++; $display("FAIL badchk_byte%0d got %h want %h", k, outq[k], want[k]); end
    end
    tests_run++; if (err_pulses != 1)     begin tests_failed++; $display("FAIL badchk_err_pulses got %0d want 1", err_pulses); end
    tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("FAIL badchk_err_count got %0d want 1", err_count); end
  endtask

  task automatic test_zero_len();
    bit ok;
    stim = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h42, 8'hBE};
    run_stim(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL zero_timeout got 0 want 1"); end
    tests_run++; if (outq.size() != 1) begin tests_failed++; $display("FAIL zero_count got %0d want 1", outq.size()); end
    if (outq.size() > 0) begin
      tests_run++; if (outq[0] !== 10'h342) begin tests_failed++; $display("FAIL zero_byte got %h want 342", outq[0]); end
    end
    tests_run++; if (err_pulses != 0) begin tests_failed++; $display("FAIL zero_err_pulses got %0d want 0", err_pulses); end
  endtask

  task automatic test_oversize();
    bit ok;
    stim = {8'hA5, 8'h41, 8'hA5, 8'h02, 8'h01, 8'hAA, 8'hBB, 8'h98};
    push_frame(MAX_LEN, 1);
    run_stim(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL oversize_timeout got 0 want 1"); end
    tests_run++; if (outq.size() != 3 + MAX_LEN + 1) begin tests_failed++; $display("FAIL oversize_count got %0d want %0d", outq.size(), 3 + MAX_LEN + 1); end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      tests_run++; if (outq[k] !== exp_q[k]) begin tests_failed++; $display("FAIL oversize_byte%0d got %h want %h", k, outq[k], exp_q[k]); end
    end
    tests_run++; if (err_pulses != 1)     begin tests_failed++; $display("FAIL oversize_err_pulses got %0d want 1", err_pulses); end
    tests_run++; if (err_count !== 16'd2) begin tests_failed++; $display("FAIL oversize_err_count got %0d want 2", err_count); end
  endtask

  task automatic test_backpressure_gaps();
    bit ok;
    push_frame(20, 1);
    push_frame(7, 1);
    gap_at = pops + 10;
    rand_ready = 1;
    run_stim(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_timeout got 0 want 1"); end
    tests_run++; if (outq.size() != exp_q.size()) begin tests_failed++; $display("FAIL bp_count got %0d want %0d", outq.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      tests_run++; if (outq[k] !== exp_q[k]) begin tests_failed++; $display("FAIL bp_byte%0d got %h want %h", k, outq[k], exp_q[k]); end
    end
    tests_run++; if (emit_pop_viol != 0) begin tests_failed++; $display("FAIL bp_pop_in_emit got %0d want 0", emit_pop_viol); end
    tests_run++; if (hold_viol != 0)     begin tests_failed++; $display("FAIL bp_hold got %0d want 0", hold_viol); end
    tests_run++; if (err_pulses != 0)    begin tests_failed++; $display("FAIL bp_err_pulses got %0d want 0", err_pulses); end
  endtask

  task automatic test_random_stream();
    bit ok;
    logic [7:0] b;
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 5))
        0: push_frame(0, 1);
        1: push_frame(MAX_LEN, 1);
        2: push_frame(int'($urandom_range(1, MAX_LEN)), 0);
        3: begin
          stim.push_back(SYNC);
          stim.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        end
        4: begin
          b = 8'($urandom);
          if (b == SYNC) b = 8'h00;
          stim.push_back(b);
        end
        default: push_frame(int'($urandom_range(1, MAX_LEN)), 1);
      endcase
    end
    rand_ready = 1;
    run_stim(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand_timeout got 0 want 1"); end
    tests_run++; if (outq.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand_count got %0d want %0d", outq.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      tests_run++; if (outq[k] !== exp_q[k]) begin tests_failed++; $display("FAIL rand_byte%0d got %h want %h", k, outq[k], exp_q[k]); end
    end
    tests_run++; if (err_pulses != exp_errs)      begin tests_failed++; $display("FAIL rand_err_pulses got %0d want %0d", err_pulses, exp_errs); end
    tests_run++; if (err_count !== 16'(err_total)) begin tests_failed++; $display("FAIL rand_err_count got %0d want %0d", err_count, err_total); end
    tests_run++; if (emit_pop_viol != 0)           begin tests_failed++; $display("FAIL rand_pop_in_emit got %0d want 0", emit_pop_viol); end
    tests_run++; if (hold_viol != 0)               begin tests_failed++; $display("FAIL rand_hold got %0d want 0", hold_viol); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_payload();
    test_valid_frame();
    test_bad_checksum();
    test_zero_len();
    test_oversize();
    test_backpressure_gaps();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
